nco_multichannel: RTL and testbench

//   Time-multiplexed, parametrised NCO. NCH independent channels share one bit-parallel

---
 rtl/nco_multichannel.sv | 253 +++++++++++++++++++++++++
 tb/tb_nco_multichannel.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_multichannel.sv
// Time-multiplexed NCO: NCH phase accumulators share one pipelined CORDIC.
// Path: launch reg -> fold reg -> NSTG micro-rotations -> round/saturate output reg.
module nco_multichannel #(
  parameter int NCH  = 4,
  parameter int PW   = 20,
  parameter int DW   = 12,
  parameter int NSTG = 12,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           En,
  input  logic           sync,
  input  logic           cfg_we,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [PW-1:0]  cfg_fcw,
  input  logic [PW-1:0]  cfg_pofs,
  input  logic [1:0]     cfg_mode,
  input  logic           cfg_clr,
  output logic           Vld,
  output logic [CHW-1:0] Ch,
  output logic [DW-1:0]  Dout
);

  // One headroom bit above the two guard bits so the CORDIC gain cannot wrap x/y.
  localparam int XW   = DW + 3;
  localparam int MAXO = (2 ** (DW - 1)) - 1;
  localparam real TWO_PI = 6.283185307179586;
  localparam int X0 = $rtoi(0.607253 * real'(MAXO) + 0.5);
  localparam logic signed [XW-1:0] X0G      = XW'(X0 * 4);
  localparam logic signed [XW:0]   RND_HALF = (XW + 1)'(2);
  localparam logic signed [XW:0]   SAT_HI   = (XW + 1)'(MAXO);
  localparam logic signed [XW:0]   SAT_LO   = -SAT_HI;

  function automatic logic [NSTG*PW-1:0] atan_table();
    logic [NSTG*PW-1:0] t;
    real a;
    t = '0;
    for (int i = 0; i < NSTG; i++) begin
      a = $atan(2.0 ** (-i)) / TWO_PI * (2.0 ** PW);
      t[i*PW +: PW] = PW'($rtoi(a + 0.5));
    end
    return t;
  endfunction

  localparam logic [NSTG*PW-1:0] ATAN_TAB = atan_table();

  logic [PW-1:0]  acc_q [NCH];
  logic [PW-1:0]  acc_d [NCH];
  logic [PW-1:0]  fcw_q [NCH];
  logic [PW-1:0]  fcw_d [NCH];
  logic [PW-1:0]  pofs_q [NCH];
  logic [PW-1:0]  pofs_d [NCH];
  logic [1:0]     mode_q [NCH];
  logic [1:0]     mode_d [NCH];
  logic [CHW-1:0] slot_q, slot_d;

  logic           l_vld_q, l_vld_d;
  logic [CHW-1:0] l_ch_q, l_ch_d;
  logic [1:0]     l_mode_q, l_mode_d;
  logic [PW-1:0]  l_phase_q, l_phase_d;

  logic                 s_vld_q  [NSTG+1];
  logic                 s_vld_d  [NSTG+1];
  logic [CHW-1:0]       s_ch_q   [NSTG+1];
  logic [CHW-1:0]       s_ch_d   [NSTG+1];
  logic [1:0]           s_mode_q [NSTG+1];
  logic [1:0]           s_mode_d [NSTG+1];
  logic                 s_neg_q  [NSTG+1];
  logic                 s_neg_d  [NSTG+1];
  logic signed [XW-1:0] x_q [NSTG+1];
  logic signed [XW-1:0] x_d [NSTG+1];
  logic signed [XW-1:0] y_q [NSTG+1];
  logic signed [XW-1:0] y_d [NSTG+1];
  logic signed [PW-1:0] z_q [NSTG];
  logic signed [PW-1:0] z_d [NSTG];

  logic           vld_q, vld_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [DW-1:0]  dout_q, dout_d;

  logic signed [XW-1:0] sel_s;
  logic signed [XW:0]   wide_s;
  logic signed [XW:0]   rnd_s;
  logic signed [XW:0]   sat_s;

  // Channel state: config writes, accumulator steps (sync > clear > increment), scheduler.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      fcw_d[c]  = fcw_q[c];
      pofs_d[c] = pofs_q[c];
      mode_d[c] = mode_q[c];
      if (cfg_we && (cfg_ch == CHW'(c))) begin
        fcw_d[c]  = cfg_fcw;
        pofs_d[c] = cfg_pofs;
        mode_d[c] = cfg_mode;
      end else begin
        fcw_d[c]  = fcw_q[c];
      end
      if (sync) begin
        acc_d[c] = '0;
      end else if (cfg_we && cfg_clr && (cfg_ch == CHW'(c))) begin
        acc_d[c] = '0;
      end else if (En && (slot_q == CHW'(c))) begin
        acc_d[c] = acc_q[c] + fcw_q[c];
      end else begin
        acc_d[c] = acc_q[c];
      end
    end
    if (sync) begin
      slot_d = '0;
    end else if (En) begin
      slot_d = (slot_q == CHW'(NCH - 1)) ? '0 : slot_q + CHW'(1);
    end else begin
      slot_d = slot_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        acc_q[c]  <= '0;
        fcw_q[c]  <= '0;
        pofs_q[c] <= '0;
        mode_q[c] <= 2'b00;
      end
      slot_q <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        acc_q[c]  <= acc_d[c];
        fcw_q[c]  <= fcw_d[c];
        pofs_q[c] <= pofs_d[c];
        mode_q[c] <= mode_d[c];
      end
      slot_q <= slot_d;
    end
  end

  // Launch, fold into [-pi/2, pi/2), micro-rotations and output rounding/saturation.
  always_comb begin
    l_vld_d   = En;
    l_ch_d    = slot_q;
    l_mode_d  = mode_q[slot_q];
    l_phase_d = acc_q[slot_q] + pofs_q[slot_q];

    s_vld_d[0]  = l_vld_q;
    s_ch_d[0]   = l_ch_q;
    s_mode_d[0] = l_mode_q;
    x_d[0]      = X0G;
    y_d[0]      = '0;
    if (l_phase_q[PW-1] != l_phase_q[PW-2]) begin
      z_d[0]     = l_phase_q ^ {1'b1, {(PW-1){1'b0}}};
      s_neg_d[0] = 1'b1;
    end else begin
      z_d[0]     = l_phase_q;
      s_neg_d[0] = 1'b0;
    end

    for (int i = 0; i < NSTG; i++) begin
      s_vld_d[i+1]  = s_vld_q[i];
      s_ch_d[i+1]   = s_ch_q[i];
      s_mode_d[i+1] = s_mode_q[i];
      s_neg_d[i+1]  = s_neg_q[i];
      if (!z_q[i][PW-1]) begin
        x_d[i+1] = x_q[i] - (y_q[i] >>> i);
        y_d[i+1] = y_q[i] + (x_q[i] >>> i);
      end else begin
        x_d[i+1] = x_q[i] + (y_q[i] >>> i);
        y_d[i+1] = y_q[i] - (x_q[i] >>> i);
      end
    end
    for (int i = 1; i < NSTG; i++) begin
      if (!z_q[i-1][PW-1]) begin
        z_d[i] = z_q[i-1] - ATAN_TAB[(i-1)*PW +: PW];
      end else begin
        z_d[i] = z_q[i-1] + ATAN_TAB[(i-1)*PW +: PW];
      end
    end

    sel_s = s_mode_q[NSTG][1] ? y_q[NSTG] : x_q[NSTG];
    if (s_neg_q[NSTG] ^ s_mode_q[NSTG][0]) begin
      wide_s = -{sel_s[XW-1], sel_s};
    end else begin
      wide_s = {sel_s[XW-1], sel_s};
    end
    rnd_s = (wide_s + RND_HALF) >>> 2;
    if (rnd_s > SAT_HI) begin
      sat_s = SAT_HI;
    end else if (rnd_s < SAT_LO) begin
      sat_s = SAT_LO;
    end else begin
      sat_s = rnd_s;
    end

    vld_d = s_vld_q[NSTG];
    if (s_vld_q[NSTG]) begin
      ch_d   = s_ch_q[NSTG];
      dout_d = sat_s[DW-1:0];
    end else begin
      ch_d   = ch_q;
      dout_d = dout_q;
    end
  end

  // Pipeline and output registers; reset discards everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_vld_q   <= 1'b0;
      l_ch_q    <= '0;
      l_mode_q  <= 2'b00;
      l_phase_q <= '0;
      for (int i = 0; i <= NSTG; i++) begin
        s_vld_q[i]  <= 1'b0;
        s_ch_q[i]   <= '0;
        s_mode_q[i] <= 2'b00;
        s_neg_q[i]  <= 1'b0;
        x_q[i]      <= '0;
        y_q[i]      <= '0;
      end
      for (int i = 0; i < NSTG; i++) begin
        z_q[i] <= '0;
      end
      vld_q  <= 1'b0;
      ch_q   <= '0;
      dout_q <= '0;
    end else begin
      l_vld_q   <= l_vld_d;
      l_ch_q    <= l_ch_d;
      l_mode_q  <= l_mode_d;
      l_phase_q <= l_phase_d;
      for (int i = 0; i <= NSTG; i++) begin
        s_vld_q[i]  <= s_vld_d[i];
        s_ch_q[i]   <= s_ch_d[i];
        s_mode_q[i] <= s_mode_d[i];
        s_neg_q[i]  <= s_neg_d[i];
        x_q[i]      <= x_d[i];
        y_q[i]      <= y_d[i];
      end
      for (int i = 0; i < NSTG; i++) begin
        z_q[i] <= z_d[i];
      end
      vld_q  <= vld_d;
      ch_q   <= ch_d;
      dout_q <= dout_d;
    end
  end

  assign Vld  = vld_q;
  assign Ch   = ch_q;
  assign Dout = dout_q;

endmodule

// File: tb/tb_nco_multichannel.sv
// Bench for nco_multichannel: per-cycle check against an ideal trig model of each
// channel, plus hand-computed sample values for the directed scenarios.
module tb_nco_multichannel;
  localparam int NCH = 4, PW = 20, DW = 12, NSTG = 12, CHW = 2;
  localparam int LAT = NSTG + 2;
  localparam int TOL = 2;
  localparam real PI = 3.141592653589793;

  logic clk = 1'b0;
  logic rst_n, En, sync, cfg_we, cfg_clr;
  logic [CHW-1:0] cfg_ch;
  logic [PW-1:0] cfg_fcw, cfg_pofs;
  logic [1:0] cfg_mode;
  logic Vld;
  logic [CHW-1:0] Ch;
  logic [DW-1:0] Dout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nco_multichannel #(.NCH(NCH), .PW(PW), .DW(DW), .NSTG(NSTG)) dut (
    .clk(clk), .rst_n(rst_n), .En(En), .sync(sync), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_fcw(cfg_fcw), .cfg_pofs(cfg_pofs), .cfg_mode(cfg_mode), .cfg_clr(cfg_clr),
    .Vld(Vld), .Ch(Ch), .Dout(Dout)
  );

  typedef struct {int due; int ch; int val;} smp_t;
  smp_t pend[$];
  logic [PW-1:0] m_acc [NCH];
  logic [PW-1:0] m_fcw [NCH];
  logic [PW-1:0] m_pofs [NCH];
  logic [1:0] m_mode [NCH];
  int m_slot = 0;
  int ecount = 0;
  int last_ch = 0, last_val = 0;
  int log_edge[$], log_ch[$], log_val[$];

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Ideal sample: amplitude 2047 cos/sin of the phase angle, optionally negated.
  function automatic int ideal(input logic [PW-1:0] ph, input logic [1:0] md);
    real th, v, x;
    th = 2.0 * PI * real'(ph) / (2.0 ** PW);
    v = md[1] ? $sin(th) : $cos(th);
    if (md[0]) v = -v;
    x = v * 2047.0;
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction

  task automatic check(input string name, input bit ok, input int act, input int req);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (edge %0d)", name, act, req, ecount);
    end
  endtask

  // Model update at each edge, then comparison of the DUT outputs 1 time unit later.
  initial begin
    smp_t s;
    logic [PW-1:0] ph;
    bit exp_v;
    int d;
    forever begin
      @(posedge clk);
      ecount++;
      if (!rst_n) begin
        for (int c = 0; c < NCH; c++) begin
          m_acc[c] = '0; m_fcw[c] = '0; m_pofs[c] = '0; m_mode[c] = 2'b00;
        end
        m_slot = 0;
        pend.delete();
        last_ch = 0;
        last_val = 0;
      end else begin
        if (En) begin
          ph = m_acc[m_slot] + m_pofs[m_slot];
          s.due = ecount + LAT;
          s.ch = m_slot;
          s.val = ideal(ph, m_mode[m_slot]);
          pend.push_back(s);
        end
        for (int c = 0; c < NCH; c++) begin
          if (sync) m_acc[c] = '0;
          else if (cfg_we && cfg_clr && int'(cfg_ch) == c) m_acc[c] = '0;
          else if (En && m_slot == c) m_acc[c] = m_acc[c] + m_fcw[c];
        end
        if (cfg_we && int'(cfg_ch) < NCH) begin
          m_fcw[cfg_ch] = cfg_fcw;
          m_pofs[cfg_ch] = cfg_pofs;
          m_mode[cfg_ch] = cfg_mode;
        end
        if (sync) m_slot = 0;
        else if (En) m_slot = (m_slot + 1) % NCH;
      end
      #1;
      exp_v = (pend.size() > 0) && (pend[0].due == ecount);
      check("vld", Vld === exp_v, int'(Vld), int'(exp_v));
      d = $signed(Dout);
      if (exp_v) begin
        s = pend.pop_front();
        check("ch", int'(Ch) == s.ch, int'(Ch), s.ch);
        check("dout", iabs(d - s.val) <= TOL, d, s.val);
        last_ch = s.ch;
        last_val = s.val;
        log_edge.push_back(ecount);
        log_ch.push_back(int'(Ch));
        log_val.push_back(d);
      end else begin
        check("ch_hold", int'(Ch) == last_ch, int'(Ch), last_ch);
        check("dout_hold", iabs(d - last_val) <= TOL, d, last_val);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg(input int ch, input int fcw, input int pofs, input int mode, input bit clr);
    cfg_we = 1'b1; cfg_ch = CHW'(ch); cfg_fcw = PW'(fcw); cfg_pofs = PW'(pofs);
    cfg_mode = 2'(mode); cfg_clr = clr;
    tick(1);
    cfg_we = 1'b0; cfg_clr = 1'b0;
  endtask

  task automatic pulse_sync();
    sync = 1'b1;
    tick(1);
    sync = 1'b0;
  endtask

  function automatic int find_log(input int edge_no);
    int k = -1;
    foreach (log_edge[i]) if (log_edge[i] == edge_no) k = i;
    return k;
  endfunction

  // Sample issued at edge ie must emerge LAT edges later with the given tag and value.
  task automatic chk_at(input string name, input int ie, input int ech, input int ev);
    int k;
    k = find_log(ie + LAT);
    if (k < 0) begin
      check({name, "_present"}, 1'b0, -1, ie + LAT);
    end else begin
      check({name, "_ch"}, log_ch[k] == ech, log_ch[k], ech);
      check({name, "_val"}, iabs(log_val[k] - ev) <= TOL, log_val[k], ev);
    end
  endtask

  task automatic chk_pair(input string name, input int ea, input int eb, input bit negated);
    int ka, kb, r;
    ka = find_log(ea + LAT);
    kb = find_log(eb + LAT);
    if (ka < 0 || kb < 0) begin
      check({name, "_present"}, 1'b0, -1, ea + LAT);
    end else begin
      r = negated ? log_val[ka] + log_val[kb] : log_val[ka] - log_val[kb];
      check(name, iabs(r) <= 2 * TOL, r, 0);
    end
  endtask

  initial begin
    int e0, e3, e5, es, n0, n4, iss;
    int q[4];
    q[0] = 2047; q[1] = 0; q[2] = -2047; q[3] = 0;
    rst_n = 1'b0; En = 1'b0; sync = 1'b0; cfg_we = 1'b0; cfg_clr = 1'b0;
    cfg_ch = '0; cfg_fcw = '0; cfg_pofs = '0; cfg_mode = 2'b00;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Quarter-rate cosine on ch0, ch1..3 idle at phase 0.
    cfg(0, 1 << (PW - 2), 0, 0, 1'b0);
    n0 = log_edge.size();
    e0 = ecount + 1;
    En = 1'b1;
    tick(32);
    En = 1'b0;
    tick(LAT + 2);
    if (log_edge.size() > n0) check("first_vld_edge", log_edge[n0] == e0 + LAT, log_edge[n0], e0 + LAT);
    else check("first_vld_present", 1'b0, 0, 1);
    for (int k = 0; k < 8; k++) chk_at("qcos", e0 + 4 * k, 0, q[k % 4]);
    for (int c = 1; c < NCH; c++) chk_at("idle", e0 + c, c, 2047);
    for (int k = 0; k < 16; k++)
      if (log_edge.size() > n0 + k) check("ch_seq", log_ch[n0 + k] == k % 4, log_ch[n0 + k], k % 4);

    // Asynchronous reset in the middle of a stream.
    En = 1'b1;
    tick(LAT + 3);
    check("pre_reset_vld", Vld == 1'b1, int'(Vld), 1);
    rst_n = 1'b0;
    #1;
    check("rst_vld", Vld == 1'b0, int'(Vld), 0);
    check("rst_dout", Dout == '0, int'(Dout), 0);
    check("rst_ch", Ch == '0, int'(Ch), 0);
    tick(2);
    En = 1'b0;
    rst_n = 1'b1;
    n0 = log_edge.size();
    tick(LAT + 6);
    check("idle_after_reset", log_edge.size() == n0, log_edge.size(), n0);

    // Phase offset vs sin mode, then selSign.
    cfg(1, 12345, 1 << (PW - 2), 0, 1'b0);
    cfg(2, 12345, 0, 2, 1'b0);
    pulse_sync();
    e3 = ecount + 1;
    En = 1'b1;
    tick(24);
    cfg(2, 12345, 0, 3, 1'b0);
    tick(24);
    En = 1'b0;
    tick(LAT + 2);
    for (int k = 0; k < 5; k++) chk_pair("ch1_neg_ch2", e3 + 1 + 4 * k, e3 + 2 + 4 * k, 1'b1);
    for (int k = 7; k < 11; k++) chk_pair("ch1_eq_ch2", e3 + 1 + 4 * k, e3 + 2 + 4 * k, 1'b0);

    // Enable gaps 1,0,0,1.
    cfg(0, 1 << (PW - 2), 0, 0, 1'b0);
    cfg(1, 3000, 777, 1, 1'b0);
    cfg(2, 99999, 0, 2, 1'b0);
    cfg(3, 1 << (PW - 1), 5, 3, 1'b0);
    pulse_sync();
    n4 = log_edge.size();
    iss = 0;
    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < 4; j++) begin
        En = (j == 0 || j == 3);
        if (En) iss++;
        tick(1);
      end
    end
    En = 1'b0;
    tick(LAT + 2);
    check("gap_count", log_edge.size() - n4 == iss, log_edge.size() - n4, iss);
    for (int k = 0; k < iss; k++)
      if (log_edge.size() > n4 + k) check("gap_ch_seq", log_ch[n4 + k] == k % 4, log_ch[n4 + k], k % 4);
    for (int k = 0; k < 3; k++)
      if (log_edge.size() > n4 + 4 * k)
        check("gap_ch0_val", iabs(log_val[n4 + 4 * k] - q[k]) <= TOL, log_val[n4 + 4 * k], q[k]);

    // Config collision on ch0's issue edge, then collision with clear.
    pulse_sync();
    e5 = ecount + 1;
    En = 1'b1;
    tick(4);
    cfg(0, 1 << (PW - 3), 0, 0, 1'b0);
    tick(11);
    cfg(0, 1 << (PW - 3), 0, 0, 1'b1);
    tick(12);
    En = 1'b0;
    tick(LAT + 2);
    chk_at("coll0", e5, 0, 2047);
    chk_at("coll1", e5 + 4, 0, 0);
    chk_at("coll2", e5 + 8, 0, -2047);
    chk_at("coll3", e5 + 12, 0, -1447);
    chk_at("clr0", e5 + 16, 0, 0);
    chk_at("clr1", e5 + 20, 0, 2047);
    chk_at("clr2", e5 + 24, 0, 1447);

    // sync mid-run: next issue is ch0 at phase = pofs[0].
    cfg(0, 1 << (PW - 2), 1 << (PW - 3), 0, 1'b0);
    En = 1'b1;
    tick(6);
    es = ecount + 1;
    pulse_sync();
    tick(8);
    En = 1'b0;
    tick(LAT + 2);
    chk_at("sync_next", es + 1, 0, 1447);
    chk_at("sync_next2", es + 5, 0, -1447);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
